// File: rtl/tlb_page_walker.sv
// Two-level hardware page-table walker feeding the tlb update port.
// One walk in flight: fetch the level-1 directory entry, then the level-2 PTE,
// then write a single tlb entry. A non-present level-1 entry writes a negative
// entry and pulses walk_fault. abort_en cancels a walk; if a read is still
// outstanding, its response is drained before the walker goes idle again.
module tlb_page_walker #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned L1_BITS         = 10,
    parameter int unsigned PAGE_INDEX_BITS = 20,
    parameter int unsigned ASID_WIDTH      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       miss_valid,
    output logic                       miss_ready,
    input  logic [PAGE_INDEX_BITS-1:0] miss_vpage_idx,
    input  logic [ASID_WIDTH-1:0]      miss_asid,
    input  logic [ADDR_WIDTH-1:0]      page_dir_base,
    input  logic                       abort_en,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [ADDR_WIDTH-1:0]      mem_req_addr,
    input  logic                       mem_resp_valid,
    input  logic [31:0]                mem_resp_data,
    output logic                       update_en,
    output logic [PAGE_INDEX_BITS-1:0] update_vpage_idx,
    output logic [ASID_WIDTH-1:0]      update_asid,
    output logic [PAGE_INDEX_BITS-1:0] update_ppage_idx,
    output logic                       update_present,
    output logic                       update_exe_writable,
    output logic                       update_supervisor,
    output logic                       update_global,
    output logic                       walk_fault,
    output logic                       busy
);

    localparam int unsigned L2_BITS = PAGE_INDEX_BITS - L1_BITS;

    typedef enum logic [2:0] {
        StIdle,
        StL1Req,
        StL1Wait,
        StL2Req,
        StL2Wait,
        StWrite,
        StDrain
    } state_e;

    state_e                       state_q, state_d;
    logic [PAGE_INDEX_BITS-1:0]   vpage_q;
    logic [ASID_WIDTH-1:0]        asid_q;
    logic [ADDR_WIDTH-1:0]        addr_q;
    logic [PAGE_INDEX_BITS-1:0]   ppage_q;
    logic [3:0]                   flags_q;   // {global, supervisor, exe_writable, present}
    logic                         fault_q;

    logic                         latch_req;
    logic                         load_l2_addr;
    logic                         load_pte;
    logic                         load_fault;
    logic [ADDR_WIDTH-1:0]        l1_addr;
    logic [ADDR_WIDTH-1:0]        l2_addr;

    // PTE bits [11:4] are reserved and carry no meaning for the tlb.
    logic                         unused_pte_bits;
    assign unused_pte_bits = ^mem_resp_data[11:4];

    // Directory offset wraps modulo the physical address space.
    assign l1_addr = page_dir_base
                   + ADDR_WIDTH'({miss_vpage_idx[PAGE_INDEX_BITS-1 -: L1_BITS], 2'b00});
    assign l2_addr = ADDR_WIDTH'({mem_resp_data[31:12], vpage_q[L2_BITS-1:0], 2'b00});

    // Next-state and handshake decode; abort_en outranks every other event.
    always_comb begin
        state_d       = state_q;
        miss_ready    = 1'b0;
        mem_req_valid = 1'b0;
        update_en     = 1'b0;
        walk_fault    = 1'b0;
        latch_req     = 1'b0;
        load_l2_addr  = 1'b0;
        load_pte      = 1'b0;
        load_fault    = 1'b0;
        unique case (state_q)
            StIdle: begin
                miss_ready = !abort_en;
                if (!abort_en && miss_valid) begin
                    latch_req = 1'b1;
                    state_d   = StL1Req;
                end
            end
            StL1Req, StL2Req: begin
                mem_req_valid = 1'b1;
                if (abort_en) begin
                    // A request accepted in the abort cycle still owes us a response.
                    state_d = mem_req_ready ? StDrain : StIdle;
                end else if (mem_req_ready) begin
                    state_d = (state_q == StL1Req) ? StL1Wait : StL2Wait;
                end
            end
            StL1Wait: begin
                if (abort_en) begin
                    state_d = mem_resp_valid ? StIdle : StDrain;
                end else if (mem_resp_valid) begin
                    if (mem_resp_data[0]) begin
                        load_l2_addr = 1'b1;
                        state_d      = StL2Req;
                    end else begin
                        load_fault = 1'b1;
                        state_d    = StWrite;
                    end
                end
            end
            StL2Wait: begin
                if (abort_en) begin
                    state_d = mem_resp_valid ? StIdle : StDrain;
                end else if (mem_resp_valid) begin
                    load_pte = 1'b1;
                    state_d  = StWrite;
                end
            end
            StWrite: begin
                update_en  = !abort_en;
                walk_fault = !abort_en && fault_q;
                state_d    = StIdle;
            end
            StDrain: begin
                if (mem_resp_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register plus latched request, request address and pending tlb entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            vpage_q <= '0;
            asid_q  <= '0;
            addr_q  <= '0;
            ppage_q <= '0;
            flags_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_req) begin
                vpage_q <= miss_vpage_idx;
                asid_q  <= miss_asid;
                addr_q  <= l1_addr;
                fault_q <= 1'b0;
            end
            if (load_l2_addr) begin
                addr_q <= l2_addr;
            end
            if (load_pte) begin
                ppage_q <= PAGE_INDEX_BITS'(mem_resp_data[31:12]);
                flags_q <= mem_resp_data[3:0];
                fault_q <= 1'b0;
            end
            if (load_fault) begin
                ppage_q <= '0;
                flags_q <= '0;
                fault_q <= 1'b1;
            end
        end
    end

    assign mem_req_addr        = mem_req_valid ? addr_q : '0;
    assign update_vpage_idx    = vpage_q;
    assign update_asid         = asid_q;
    assign update_ppage_idx    = ppage_q;
    assign update_present      = flags_q[0];
    assign update_exe_writable = flags_q[1];
    assign update_supervisor   = flags_q[2];
    assign update_global       = flags_q[3];
    assign busy                = (state_q != StIdle);

endmodule
